// File: rtl/riptide_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riptide_pkg
// Description : Shared constants for the RIPTIDE execute pipeline: ALU opcode
//               encodings and the index of the auxiliary B-operand register.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package riptide_pkg;

    // ALU opcodes carried on alu_op; encodings 6 and 7 decode as MOVE.
    localparam logic [2:0] OP_MOVE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;

    // R0 supplies the B operand whenever imm_sel is low.
    localparam int unsigned R0_IDX = 0;

endpackage
`default_nettype wire

// File: rtl/riptide_regfile.sv
`default_nettype none
// ============================================================================
// Module      : riptide_regfile
// Description : NREGS x WIDTH register file, one write port, two read ports
//               (addressed A operand and fixed R0). Reads are write-through:
//               a write landing on the same edge is visible on the read port.
// Revision    : 1.0 - initial parametrised release
// Ports       : clk, RST (async, active-high)
//               stall            - blocks the write
//               wr_en/addr/data  - write port
//               rd_addr/rd_data  - A-operand read port
//               r0_data          - R0 read port
// ============================================================================
module riptide_regfile
    import riptide_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     stall,
    input  logic                     wr_en,
    input  logic [$clog2(NREGS)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic [WIDTH-1:0]         r0_data
);

    localparam int RW = $clog2(NREGS);

    logic [WIDTH-1:0] r_mem [NREGS];
    logic             w_wr;

    assign w_wr = wr_en & ~stall;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Bypass the write data so an op reading a register that is being
    // written on this same edge sees the new value without interlocking.
    assign rd_data = (w_wr && (wr_addr == rd_addr))     ? wr_data : r_mem[rd_addr];
    assign r0_data = (w_wr && (wr_addr == RW'(R0_IDX))) ? wr_data : r_mem[R0_IDX];

endmodule
`default_nettype wire

// File: rtl/riptide_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : riptide_exec_pipe
// Description : Three-stage execute pipeline: register read at issue,
//               S1 -> right-rotate -> S2 -> mask -> S3 -> ALU -> result and
//               register-file write. Includes a RAW interlock against S1/S2
//               producers; S3 producers are covered by regfile write-through.
// Revision    : 1.0 - initial parametrised release
// Ports       : clk, RST (async, active-high), stall, flush
//               issue_valid/issue_ready handshake with decode
//               src, dst, wren, io_sel, io_in, rot, mlen, alu_op, imm_sel, imm
//               result, result_valid, result_dst, nz, ovf
// ============================================================================
module riptide_exec_pipe
    import riptide_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [$clog2(NREGS)-1:0] src,
    input  logic [$clog2(NREGS)-1:0] dst,
    input  logic                     wren,
    input  logic                     io_sel,
    input  logic [WIDTH-1:0]         io_in,
    input  logic [$clog2(WIDTH)-1:0] rot,
    input  logic [$clog2(WIDTH)-1:0] mlen,
    input  logic [2:0]               alu_op,
    input  logic                     imm_sel,
    input  logic [WIDTH-1:0]         imm,
    output logic [WIDTH-1:0]         result,
    output logic                     result_valid,
    output logic [$clog2(NREGS)-1:0] result_dst,
    output logic                     nz,
    output logic                     ovf
);

    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);

    // ---------------- stage registers ----------------
    logic             r_s1_valid, r_s1_wren;
    logic [RW-1:0]    r_s1_dst;
    logic [WIDTH-1:0] r_s1_a, r_s1_b;
    logic [SW-1:0]    r_s1_rot, r_s1_mlen;
    logic [2:0]       r_s1_op;

    logic             r_s2_valid, r_s2_wren;
    logic [RW-1:0]    r_s2_dst;
    logic [WIDTH-1:0] r_s2_a, r_s2_b;
    logic [SW-1:0]    r_s2_mlen;
    logic [2:0]       r_s2_op;

    logic             r_s3_valid, r_s3_wren;
    logic [RW-1:0]    r_s3_dst;
    logic [WIDTH-1:0] r_s3_a, r_s3_b;
    logic [2:0]       r_s3_op;

    logic [WIDTH-1:0] r_result;
    logic             r_result_valid;
    logic [RW-1:0]    r_result_dst;
    logic             r_nz, r_ovf;

    // ---------------- combinational ----------------
    logic [WIDTH-1:0] w_rf_a, w_rf_r0;
    logic             w_haz_s1, w_haz_s2, w_issue;
    logic [SW-1:0]    w_lsh;
    logic [WIDTH-1:0] w_rot, w_mask, w_masked;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_alu;
    logic             w_arith, w_carry;
    logic             w_rf_we;

    assign w_rf_we = r_s3_valid & r_s3_wren;

    riptide_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .RST     (RST),
        .stall   (stall),
        .wr_en   (w_rf_we),
        .wr_addr (r_s3_dst),
        .wr_data (w_alu),
        .rd_addr (src),
        .rd_data (w_rf_a),
        .r0_data (w_rf_r0)
    );

    // An op in S1 or S2 that will write a register this issue reads must
    // reach S3 first, where write-through forwards its result.
    assign w_haz_s1 = r_s1_valid & r_s1_wren &
                      ((~io_sel  & (r_s1_dst == src)) |
                       (~imm_sel & (r_s1_dst == RW'(R0_IDX))));
    assign w_haz_s2 = r_s2_valid & r_s2_wren &
                      ((~io_sel  & (r_s2_dst == src)) |
                       (~imm_sel & (r_s2_dst == RW'(R0_IDX))));

    assign issue_ready = ~stall & ~w_haz_s1 & ~w_haz_s2;
    assign w_issue     = issue_valid & issue_ready & ~flush;

    // Right rotate: the left-shift amount is (WIDTH - rot) mod WIDTH, which
    // is exactly the SW-bit negation of rot; rot = 0 degenerates to a | a.
    assign w_lsh = -r_s1_rot;
    assign w_rot = (r_s1_a >> r_s1_rot) | (r_s1_a << w_lsh);

    // Keep bits [mlen:0]: equivalent to (2 << mlen) - 1 without needing a
    // WIDTH+1 intermediate; mlen = WIDTH-1 shifts the ones fully out.
    assign w_mask   = ~(({WIDTH{1'b1}} << r_s2_mlen) << 1);
    assign w_masked = r_s2_a & w_mask;

    assign w_sum  = {1'b0, r_s3_a} + {1'b0, r_s3_b};
    assign w_diff = {1'b0, r_s3_a} - {1'b0, r_s3_b};

    always_comb begin
        w_alu   = r_s3_a;
        w_arith = 1'b0;
        w_carry = 1'b0;
        case (r_s3_op)
            OP_ADD: begin
                w_alu   = w_sum[WIDTH-1:0];
                w_arith = 1'b1;
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu   = w_diff[WIDTH-1:0];
                w_arith = 1'b1;
                w_carry = w_diff[WIDTH];   // borrow out
            end
            OP_AND:  w_alu = r_s3_a & r_s3_b;
            OP_XOR:  w_alu = r_s3_a ^ r_s3_b;
            OP_OR:   w_alu = r_s3_a | r_s3_b;
            default: w_alu = r_s3_a;
        endcase
    end

    // ---------------- pipeline advance ----------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_s1_valid     <= 1'b0;
            r_s1_wren      <= 1'b0;
            r_s1_dst       <= '0;
            r_s1_a         <= '0;
            r_s1_b         <= '0;
            r_s1_rot       <= '0;
            r_s1_mlen      <= '0;
            r_s1_op        <= '0;
            r_s2_valid     <= 1'b0;
            r_s2_wren      <= 1'b0;
            r_s2_dst       <= '0;
            r_s2_a         <= '0;
            r_s2_b         <= '0;
            r_s2_mlen      <= '0;
            r_s2_op        <= '0;
            r_s3_valid     <= 1'b0;
            r_s3_wren      <= 1'b0;
            r_s3_dst       <= '0;
            r_s3_a         <= '0;
            r_s3_b         <= '0;
            r_s3_op        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_dst   <= '0;
            r_nz           <= 1'b0;
            r_ovf          <= 1'b0;
        end else if (!stall) begin
            // Flush kills the incoming issue (inside w_issue) and whatever
            // sits in S1/S2; the S3 op still retires below.
            r_s1_valid <= w_issue;
            r_s1_wren  <= wren;
            r_s1_dst   <= dst;
            r_s1_a     <= io_sel  ? io_in : w_rf_a;
            r_s1_b     <= imm_sel ? imm   : w_rf_r0;
            r_s1_rot   <= rot;
            r_s1_mlen  <= mlen;
            r_s1_op    <= alu_op;

            r_s2_valid <= r_s1_valid & ~flush;
            r_s2_wren  <= r_s1_wren;
            r_s2_dst   <= r_s1_dst;
            r_s2_a     <= w_rot;
            r_s2_b     <= r_s1_b;
            r_s2_mlen  <= r_s1_mlen;
            r_s2_op    <= r_s1_op;

            r_s3_valid <= r_s2_valid & ~flush;
            r_s3_wren  <= r_s2_wren;
            r_s3_dst   <= r_s2_dst;
            r_s3_a     <= w_masked;
            r_s3_b     <= r_s2_b;
            r_s3_op    <= r_s2_op;

            r_result_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_result     <= w_alu;
                r_result_dst <= r_s3_dst;
                r_nz         <= |w_alu;
                if (w_arith) begin
                    r_ovf <= w_carry;
                end
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_dst   = r_result_dst;
    assign nz           = r_nz;
    assign ovf          = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_riptide_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_riptide_exec_pipe
// Description : Directed self-checking bench for riptide_exec_pipe. One
//               8-bit/8-register instance exercises interlock, rotate/mask,
//               throughput, flush and stall; a 16-bit/16-register instance
//               covers SUB borrow and asynchronous reset mid-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riptide_exec_pipe;
    import riptide_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-bit instance ----------------
    logic       RST, stall, flush, issue_valid, issue_ready;
    logic [2:0] src, dst, rot, mlen, alu_op, result_dst;
    logic       wren, io_sel, imm_sel, result_valid, nz, ovf;
    logic [7:0] io_in, imm, result;

    riptide_exec_pipe #(.WIDTH(8), .NREGS(8)) u_dut (
        .clk(clk), .RST(RST), .stall(stall), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .src(src), .dst(dst), .wren(wren), .io_sel(io_sel), .io_in(io_in),
        .rot(rot), .mlen(mlen), .alu_op(alu_op), .imm_sel(imm_sel), .imm(imm),
        .result(result), .result_valid(result_valid), .result_dst(result_dst),
        .nz(nz), .ovf(ovf)
    );

    // ---------------- 16-bit instance ----------------
    logic        b_RST, b_stall, b_flush, b_issue_valid, b_issue_ready;
    logic [3:0]  b_src, b_dst, b_rot, b_mlen, b_result_dst;
    logic [2:0]  b_alu_op;
    logic        b_wren, b_io_sel, b_imm_sel, b_result_valid, b_nz, b_ovf;
    logic [15:0] b_io_in, b_imm, b_result;

    riptide_exec_pipe #(.WIDTH(16), .NREGS(16)) u_dut_w16 (
        .clk(clk), .RST(b_RST), .stall(b_stall), .flush(b_flush),
        .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
        .src(b_src), .dst(b_dst), .wren(b_wren), .io_sel(b_io_sel), .io_in(b_io_in),
        .rot(b_rot), .mlen(b_mlen), .alu_op(b_alu_op), .imm_sel(b_imm_sel), .imm(b_imm),
        .result(b_result), .result_valid(b_result_valid), .result_dst(b_result_dst),
        .nz(b_nz), .ovf(b_ovf)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] last_res;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for issue_ready, take the accepting edge.
    // Returns one time unit after that edge with issue_valid dropped.
    task automatic send(input logic [2:0] t_src, input logic [2:0] t_dst,
                        input logic t_wren, input logic t_io_sel, input logic [7:0] t_io_in,
                        input logic [2:0] t_rot, input logic [2:0] t_mlen, input logic [2:0] t_op,
                        input logic t_imm_sel, input logic [7:0] t_imm, output int n_wait);
        src = t_src; dst = t_dst; wren = t_wren; io_sel = t_io_sel; io_in = t_io_in;
        rot = t_rot; mlen = t_mlen; alu_op = t_op; imm_sel = t_imm_sel; imm = t_imm;
        issue_valid = 1'b1;
        #1;
        n_wait = 0;
        while (!issue_ready && n_wait < 10) begin
            tick();
            n_wait++;
        end
        if (!issue_ready) chk("issue_timeout", 32'(issue_ready), 32'd1);
        else tick();
        issue_valid = 1'b0;
    endtask

    task automatic mov_io(input logic [2:0] d, input logic [7:0] v);
        int w;
        send(3'd0, d, 1'b1, 1'b1, v, 3'd0, 3'd7, OP_MOVE, 1'b1, 8'h00, w);
    endtask

    // Serial read-style op (no write-back); checks the result 3 edges later.
    task automatic rd_chk(input string tag, input logic [2:0] s, input logic [2:0] r,
                          input logic [2:0] m, input logic [2:0] op, input logic [7:0] im,
                          input logic [7:0] exp);
        int w;
        send(s, 3'd0, 1'b0, 1'b0, 8'h00, r, m, op, 1'b1, im, w);
        repeat (3) tick();
        chk({tag, "_vld"}, 32'(result_valid), 32'd1);
        chk(tag, 32'(result), 32'(exp));
        last_res = exp;
    endtask

    task automatic send_b(input logic [3:0] t_src, input logic [3:0] t_dst, input logic t_wren,
                          input logic t_io_sel, input logic [15:0] t_io_in, input logic [2:0] t_op,
                          input logic [15:0] t_imm, output int n_wait);
        b_src = t_src; b_dst = t_dst; b_wren = t_wren; b_io_sel = t_io_sel; b_io_in = t_io_in;
        b_rot = 4'd0; b_mlen = 4'd15; b_alu_op = t_op; b_imm_sel = 1'b1; b_imm = t_imm;
        b_issue_valid = 1'b1;
        #1;
        n_wait = 0;
        while (!b_issue_ready && n_wait < 10) begin
            tick();
            n_wait++;
        end
        if (!b_issue_ready) chk("b_issue_timeout", 32'(b_issue_ready), 32'd1);
        else tick();
        b_issue_valid = 1'b0;
    endtask

    task automatic rd_b(input string tag, input logic [3:0] s, input logic [15:0] exp);
        int w;
        send_b(s, 4'd0, 1'b0, 1'b0, 16'h0, OP_MOVE, 16'h0, w);
        repeat (3) tick();
        chk({tag, "_vld"}, 32'(b_result_valid), 32'd1);
        chk(tag, 32'(b_result), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, wsum;
        RST = 1'b1; stall = 1'b0; flush = 1'b0; issue_valid = 1'b0;
        src = '0; dst = '0; wren = 1'b0; io_sel = 1'b0; io_in = '0;
        rot = '0; mlen = '0; alu_op = '0; imm_sel = 1'b0; imm = '0;
        b_RST = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_issue_valid = 1'b0;
        b_src = '0; b_dst = '0; b_wren = 1'b0; b_io_sel = 1'b0; b_io_in = '0;
        b_rot = '0; b_mlen = '0; b_alu_op = '0; b_imm_sel = 1'b0; b_imm = '0;
        last_res = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0; b_RST = 1'b0;
        #1;

        // ---- reset state ----
        chk("rst_result",  32'(result),       32'd0);
        chk("rst_valid",   32'(result_valid), 32'd0);
        chk("rst_dst",     32'(result_dst),   32'd0);
        chk("rst_nz",      32'(nz),           32'd0);
        chk("rst_ovf",     32'(ovf),          32'd0);
        chk("rst_ready",   32'(issue_ready),  32'd1);

        // ---- interlock + write-through: R0=B0, R1=5A, R2=R1+R0 ----
        mov_io(3'd0, 8'hB0);
        mov_io(3'd1, 8'h5A);
        send(3'd1, 3'd2, 1'b1, 1'b0, 8'h00, 3'd0, 3'd7, OP_ADD, 1'b0, 8'h00, w);
        chk("raw_stall_cycles", 32'(w), 32'd2);
        tick(); tick();
        chk("add_bubble", 32'(result_valid), 32'd0);
        tick();
        chk("add_vld",    32'(result_valid), 32'd1);
        chk("add_result", 32'(result),       32'h0A);
        chk("add_dst",    32'(result_dst),   32'd2);
        chk("add_nz",     32'(nz),           32'd1);
        chk("add_ovf",    32'(ovf),          32'd1);

        // ---- rotate / mask on R1 = A5 ----
        mov_io(3'd1, 8'hA5);
        rd_chk("rot4_m3", 3'd1, 3'd4, 3'd3, OP_MOVE, 8'h00, 8'h0A);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        rd_chk("rot0_m7", 3'd1, 3'd0, 3'd7, OP_MOVE, 8'h00, 8'hA5);
        rd_chk("rot1_m7", 3'd1, 3'd1, 3'd7, OP_MOVE, 8'h00, 8'hD2);
        rd_chk("rot0_m0", 3'd1, 3'd0, 3'd0, OP_MOVE, 8'h00, 8'h01);

        // ---- back-to-back independent ops (R1=A5, R2=0A) ----
        wsum = 0;
        send(3'd1, 3'd3, 1'b1, 1'b0, 8'h00, 3'd0, 3'd7, OP_ADD, 1'b1, 8'h10, w); wsum += w;
        send(3'd2, 3'd4, 1'b1, 1'b0, 8'h00, 3'd0, 3'd7, OP_XOR, 1'b1, 8'hFF, w); wsum += w;
        send(3'd1, 3'd5, 1'b1, 1'b0, 8'h00, 3'd0, 3'd7, OP_AND, 1'b1, 8'h0F, w); wsum += w;
        send(3'd2, 3'd6, 1'b1, 1'b0, 8'h00, 3'd0, 3'd7, OP_SUB, 1'b1, 8'h0B, w); wsum += w;
        chk("b2b_no_stall", 32'(wsum), 32'd0);
        chk("b2b_add_vld", 32'(result_valid), 32'd1);
        chk("b2b_add",     32'(result),       32'hB5);
        chk("b2b_add_ovf", 32'(ovf),          32'd0);
        tick();
        chk("b2b_xor_vld", 32'(result_valid), 32'd1);
        chk("b2b_xor",     32'(result),       32'hF5);
        tick();
        chk("b2b_and_vld", 32'(result_valid), 32'd1);
        chk("b2b_and",     32'(result),       32'h05);
        tick();
        chk("b2b_sub_vld", 32'(result_valid), 32'd1);
        chk("b2b_sub",     32'(result),       32'hFF);
        chk("b2b_sub_ovf", 32'(ovf),          32'd1);
        chk("b2b_sub_dst", 32'(result_dst),   32'd6);
        tick();
        chk("b2b_idle", 32'(result_valid), 32'd0);

        // ---- flush with ops in S1, S2, S3 ----
        mov_io(3'd7, 8'h11);
        mov_io(3'd3, 8'h22);
        mov_io(3'd4, 8'h33);
        src = 3'd0; dst = 3'd5; wren = 1'b1; io_sel = 1'b1; io_in = 8'h44;
        alu_op = OP_MOVE; imm_sel = 1'b1; rot = 3'd0; mlen = 3'd7;
        issue_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        chk("flush_s3_vld", 32'(result_valid), 32'd1);
        chk("flush_s3_res", 32'(result),       32'h11);
        chk("flush_s3_dst", 32'(result_dst),   32'd7);
        tick();
        chk("flush_kill1", 32'(result_valid), 32'd0);
        tick();
        chk("flush_kill2", 32'(result_valid), 32'd0);
        rd_chk("flush_r7",    3'd7, 3'd0, 3'd7, OP_MOVE, 8'h00, 8'h11);
        rd_chk("flush_r3_or", 3'd3, 3'd0, 3'd7, OP_OR,   8'h40, 8'hF5);
        rd_chk("flush_r4",    3'd4, 3'd0, 3'd7, OP_MOVE, 8'h00, 8'hF5);
        rd_chk("flush_r5",    3'd5, 3'd0, 3'd7, OP_MOVE, 8'h00, 8'h05);

        // ---- stall (with flush held) mid-stream ----
        send(3'd3, 3'd6, 1'b1, 1'b0, 8'h00, 3'd0, 3'd7, OP_ADD, 1'b1, 8'h01, w);
        send(3'd4, 3'd7, 1'b1, 1'b0, 8'h00, 3'd0, 3'd7, OP_XOR, 1'b1, 8'h0F, w);
        send(3'd5, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd7, OP_AND, 1'b1, 8'h04, w);
        src = 3'd0; dst = 3'd1; wren = 1'b1; io_sel = 1'b1; io_in = 8'h99;
        alu_op = OP_MOVE; imm_sel = 1'b1;
        issue_valid = 1'b1; stall = 1'b1; flush = 1'b1;
        #1;
        chk("stall_ready", 32'(issue_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_vld_frozen", 32'(result_valid), 32'd0);
            chk("stall_res_frozen", 32'(result),       32'(last_res));
        end
        stall = 1'b0; flush = 1'b0; issue_valid = 1'b0;
        tick();
        chk("post_stall_add_vld", 32'(result_valid), 32'd1);
        chk("post_stall_add",     32'(result),       32'hB6);
        chk("post_stall_add_ovf", 32'(ovf),          32'd0);
        tick();
        chk("post_stall_xor", 32'(result), 32'hFA);
        tick();
        chk("post_stall_and", 32'(result), 32'h04);
        tick();
        chk("post_stall_idle", 32'(result_valid), 32'd0);
        rd_chk("stall_r7", 3'd7, 3'd0, 3'd7, OP_MOVE, 8'h00, 8'hFA);
        rd_chk("stall_r6", 3'd6, 3'd0, 3'd7, OP_MOVE, 8'h00, 8'hB6);
        rd_chk("stall_r1", 3'd1, 3'd0, 3'd7, OP_MOVE, 8'h00, 8'hA5);

        // ---- 16-bit instance: SUB borrow, then async reset mid-stream ----
        send_b(4'd0, 4'd1, 1'b1, 1'b1, 16'h0001, OP_MOVE, 16'h0000, w);
        send_b(4'd1, 4'd2, 1'b1, 1'b0, 16'h0000, OP_SUB,  16'h0002, w);
        chk("w16_raw_stall", 32'(w), 32'd2);
        repeat (3) tick();
        chk("w16_sub_vld", 32'(b_result_valid), 32'd1);
        chk("w16_sub",     32'(b_result),       32'hFFFF);
        chk("w16_sub_ovf", 32'(b_ovf),          32'd1);
        chk("w16_sub_dst", 32'(b_result_dst),   32'd2);
        send_b(4'd0, 4'd3, 1'b1, 1'b1, 16'h1234, OP_MOVE, 16'h0000, w);
        send_b(4'd1, 4'd4, 1'b1, 1'b0, 16'h0000, OP_ADD,  16'h0005, w);
        #2;
        b_RST = 1'b1;
        #1;
        chk("w16_rst_result", 32'(b_result),       32'd0);
        chk("w16_rst_ovf",    32'(b_ovf),          32'd0);
        chk("w16_rst_nz",     32'(b_nz),           32'd0);
        chk("w16_rst_dst",    32'(b_result_dst),   32'd0);
        chk("w16_rst_vld",    32'(b_result_valid), 32'd0);
        tick();
        #2;
        b_RST = 1'b0;
        rd_b("w16_r1", 4'd1, 16'h0000);
        chk("w16_r1_nz", 32'(b_nz), 32'd0);
        rd_b("w16_r2", 4'd2, 16'h0000);
        rd_b("w16_r3", 4'd3, 16'h0000);
        rd_b("w16_r4", 4'd4, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riptide_exec_pipe.md
# riptide_exec_pipe

Parametrised execute pipeline for the next RIPTIDE core. It takes one decoded operation per cycle and performs register read, right-rotate, mask and ALU in order, then writes the result back to its own register file. Compared with the fixed 8-bit datapath, it adds configurable width and register count, an on-chip hazard interlock with write-through bypass, and SUB/OR ALU ops. It sits between the decode unit and the shift/merge and IO stages.

## Interface
Parameters:
- WIDTH, 8, datapath width; power of two, ≥ 8.
- NREGS, 8, register count; power of two, ≥ 2. R0 is the auxiliary (B-operand) register.
- Derived: RW = clog2(NREGS), SW = clog2(WIDTH).

Ports:
- clk  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- stall  in  1  freezes every stage, the register file and all outputs.
- flush  in  1  kills the incoming issue and stages S1–S2.
- issue_valid  in  1  decoded operation present.
- issue_ready  out  1  operation accepted when issue_valid & issue_ready.
- src  in  RW  A-operand register.
- dst  in  RW  destination register.
- wren  in  1  write result to dst.
- io_sel  in  1  A operand comes from io_in instead of src.
- io_in  in  WIDTH  IO operand, sampled at issue.
- rot  in  SW  right-rotate amount.
- mlen  in  SW  mask: keep bits [mlen:0].
- alu_op  in  3  0 MOVE, 1 ADD, 2 AND, 3 XOR, 4 SUB, 5 OR, 6/7 MOVE.
- imm_sel  in  1  B operand = imm, else R0.
- imm  in  WIDTH  immediate.
- result  out  WIDTH  ALU result.
- result_valid  out  1  result holds a completed operation.
- result_dst  out  RW  dst of that operation.
- nz  out  1  result ≠ 0.
- ovf  out  1  sticky-until-next-arith carry/borrow flag.

## Operation
- Pipeline: issue → S1 (A/B captured, controls) → S2 (rotated A) → S3 (masked A). The ALU operates combinationally on S3, and the result register and register file both update at the S3→out edge.
- Rotate: A rotated right by rot, modulo WIDTH. Mask: A & ((2 << mlen) − 1); mlen = WIDTH−1 passes all bits.
- ALU: MOVE = A; ADD = A+B, ovf = carry-out; SUB = A−B, ovf = borrow; AND/XOR/OR are bitwise. ovf changes only on valid ADD/SUB. nz updates on every valid completion.
- Register file read at issue, with write-through: a same-edge write to the read address returns the new value.
- Hazard: issue_ready = 0 when a valid S1 or S2 entry has wren and dst equals src (with io_sel = 0), or dst equals 0 (with imm_sel = 0). An S3 producer is covered by write-through, so there is no stall for it.
- issue_ready also = 0 during stall. It is combinational and does not depend on issue_valid.
- stall has priority. While stall = 1, flush is ignored and nothing moves. The requester holds flush until stall drops.
- flush (no stall): S1 and S2 valids are cleared, the incoming issue is dropped, and S3 completes normally.
- Invalid stages never write the register file or update nz, ovf or result.

## Timing
- Issue accepted at edge E0 → result, nz, ovf and result_valid are updated at E3, and the register file is written at E3. Latency is 3 cycles and throughput is 1 per cycle with no hazard.
- A dependent op can issue at E3 at the earliest, so at most 2 interlock cycles.
- result_valid is a one-cycle pulse per completion. It stays 0 in bubble cycles and is frozen during stall.
- Reset values: all stage valids 0, result 0, result_valid 0, result_dst 0, nz 0, ovf 0, all registers 0. issue_ready = 1 after reset.
- RST mid-operation discards all in-flight entries immediately, with no writes.

## Structure
- riptide_pkg: ALU opcode localparams (OP_MOVE, OP_ADD, OP_AND, OP_XOR, OP_SUB, OP_OR) and the R0 index constant.
- Sub-module riptide_regfile: NREGS×WIDTH, one write port, two read ports (src and R0), write-through, async RST clear, stall-gated write.
- Hazard compare, rotate, mask and ALU stay in riptide_exec_pipe.

## Test plan
- WIDTH = 8. Issue R1 = imm 0x5A (MOVE via io_sel, io_in = 0x5A), then ADD R2 = R1 + R0 with R0 = 0xB0 → result 0x0A, ovf = 1, nz = 1. The second op stalls 2 cycles (issue_ready low) and completes 3 cycles after acceptance.
- rot = 4, mlen = 3 on R1 = 0xA5 → MOVE result 0x0A. mlen = 7, rot = 0 → 0xA5.
- Back-to-back independent ops (different dst and src, imm_sel = 1) → issue_ready stays high and result_valid is high every cycle.
- flush with ops in S1, S2 and S3 → only the S3 op completes, and the register file shows only its write.
- stall for 3 cycles mid-stream, with flush asserted during the stall → outputs frozen, flush ignored, and results identical to an unstalled run.
- WIDTH = 16, NREGS = 16: SUB 0x0001 − 0x0002 → 0xFFFF, ovf = 1. Assert RST mid-stream → all outputs and registers 0 immediately.
